classify_sequencer: RTL and testbench

//  Schedules one classification per completed voxel-bin window.
//  - Reads flattened feature batches from the feature RAM.
//  - Streams them into the systolic matrix-multiply engine and collects its result.
//  - Presents the gesture on a valid/ready output.
//  - Sits between voxel-bin accumulation (window_ready) and the UART/LED reporting logic.

---
 rtl/classify_pkg.sv | 27 ++
 rtl/classify_sequencer_margin_calc.sv | 43 ++++
 rtl/classify_sequencer.sv | 156 +++++++++++++++
 tb/tb_classify_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/classify_pkg.sv
// Shared types and helpers for the classification sequencer.
//   state_t         sequencer states
//   class_t         2-bit gesture class
//   calc_batches    cells per window -> RAM words / engine beats per window
//   calc_batch_bits width of the batch index (never less than 1)
package classify_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FEED,
    S_WAIT,
    S_HOLD
  } state_t;

  typedef logic [1:0] class_t;

  function automatic int calc_batches(input int cells, input int par);
    return (cells + par - 1) / par;
  endfunction

  // A single-batch window still needs a 1-bit address port.
  function automatic int calc_batch_bits(input int batches);
    return (batches > 1) ? $clog2(batches) : 1;
  endfunction

endpackage

// File: rtl/classify_sequencer_margin_calc.sv
// margin_calc: combinational top-2 search over the engine's signed class
// scores, and the confidence decision on (best - second).
// Only instantiated when CLS_MARGIN_EN is defined.
// Ports:
//   scores_flat  in   NUM_CLASSES*ACC_BITS  signed scores, class 0 in the LSBs
//   low_conf     out  1                     (best - second) < MIN_MARGIN
module margin_calc #(
  parameter int NUM_CLASSES = 4,
  parameter int ACC_BITS    = 24,
  parameter int MIN_MARGIN  = 64
) (
  input  logic [NUM_CLASSES*ACC_BITS-1:0] scores_flat,
  output logic                            low_conf
);

  localparam logic signed [ACC_BITS:0] MIN_M = (ACC_BITS+1)'(MIN_MARGIN);

  logic signed [ACC_BITS-1:0] best;
  logic signed [ACC_BITS-1:0] second;
  logic signed [ACC_BITS-1:0] score;
  logic signed [ACC_BITS:0]   margin;

  // Second starts at the most negative value so any real score replaces it.
  // An equal score lands in 'second', so ties yield a zero margin.
  always_comb begin
    best   = signed'(scores_flat[ACC_BITS-1:0]);
    second = {1'b1, {(ACC_BITS-1){1'b0}}};
    score  = '0;
    for (int i = 1; i < NUM_CLASSES; i++) begin
      score = signed'(scores_flat[i*ACC_BITS +: ACC_BITS]);
      if (score > best) begin
        second = best;
        best   = score;
      end else if (score > second) begin
        second = score;
      end
    end
    // One extra bit so best - second cannot overflow.
    margin   = {best[ACC_BITS-1], best} - {second[ACC_BITS-1], second};
    low_conf = (margin < MIN_M);
  end

endmodule

// File: rtl/classify_sequencer.sv
// classify_sequencer: runs one classification per completed feature window.
// Reads the window batch by batch from the feature RAM, streams it to the
// matrix-multiply engine, captures the engine's argmax and presents it on a
// valid/ready gesture port. One extra window can be queued (pending); any
// further window arriving while busy is dropped and counted.
// Optional feature: define CLS_MARGIN_EN to flag low-confidence results
// whose best-minus-second score margin is below MIN_MARGIN.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   window_ready             pulse: a new window is complete
//   feat_rd_en/addr          feature RAM read port (data 1 cycle later)
//   feat_rd_data             feature RAM read data
//   mm_start                 engine start pulse
//   mm_feature_in/valid      batch stream to the engine
//   mm_result_valid          engine result pulse
//   mm_best_class            engine argmax
//   mm_scores_flat           engine signed scores (margin feature only)
//   gest_valid/ready         gesture handshake
//   gest_class, gest_low_conf gesture payload
//   busy                     sequencer not idle
//   drop_cnt                 saturating count of dropped windows
module classify_sequencer
  import classify_pkg::*;
#(
  parameter int NUM_CLASSES     = 4,
  parameter int NUM_CELLS       = 1024,
  parameter int VALUE_BITS      = 6,
  parameter int ACC_BITS        = 24,
  parameter int PARALLEL_INPUTS = 4,
  parameter int MIN_MARGIN      = 64,
  parameter int DROP_BITS       = 8,
  localparam int BATCHES        = calc_batches(NUM_CELLS, PARALLEL_INPUTS),
  localparam int BATCH_BITS     = calc_batch_bits(BATCHES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  window_ready,
  output logic                                  feat_rd_en,
  output logic [BATCH_BITS-1:0]                 feat_rd_addr,
  input  logic [PARALLEL_INPUTS*VALUE_BITS-1:0] feat_rd_data,
  output logic                                  mm_start,
  output logic [PARALLEL_INPUTS*VALUE_BITS-1:0] mm_feature_in,
  output logic                                  mm_feature_valid,
  input  logic                                  mm_result_valid,
  input  logic [1:0]                            mm_best_class,
  input  logic [NUM_CLASSES*ACC_BITS-1:0]       mm_scores_flat,
  output logic                                  gest_valid,
  input  logic                                  gest_ready,
  output logic [1:0]                            gest_class,
  output logic                                  gest_low_conf,
  output logic                                  busy,
  output logic [DROP_BITS-1:0]                  drop_cnt
);

  localparam logic [BATCH_BITS-1:0] LAST_BATCH = BATCH_BITS'(BATCHES - 1);

  state_t                state;
  state_t                state_next;
  logic                  pending;
  logic                  drop;
  logic [BATCH_BITS-1:0] counter;
  logic                  rd_en_q;
  class_t                class_q;
  logic                  low_conf_q;
  logic                  low_conf_calc;

`ifdef CLS_MARGIN_EN
  margin_calc #(
    .NUM_CLASSES (NUM_CLASSES),
    .ACC_BITS    (ACC_BITS),
    .MIN_MARGIN  (MIN_MARGIN)
  ) u_margin (
    .scores_flat (mm_scores_flat),
    .low_conf    (low_conf_calc)
  );
`else
  localparam int unused_min_margin = MIN_MARGIN;
  logic unused_scores;
  assign unused_scores = ^mm_scores_flat;
  assign low_conf_calc = 1'b0;
`endif

  // A window is dropped whenever one is already queued; in S_IDLE a queued
  // window always departs, so the same rule covers that cycle too.
  assign drop = window_ready && pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      drop_cnt   <= '0;
      counter    <= '0;
      rd_en_q    <= 1'b0;
      class_q    <= '0;
      low_conf_q <= 1'b0;
    end else begin
      state   <= state_next;
      rd_en_q <= feat_rd_en;

      if (state == S_START) begin
        counter <= '0;
      end else if (state == S_FEED) begin
        counter <= counter + 1'b1;
      end

      if (state == S_WAIT && mm_result_valid) begin
        class_q    <= mm_best_class;
        low_conf_q <= low_conf_calc;
      end

      // Leaving S_IDLE consumes the queued window; a window seen while busy
      // is queued if the slot is free.
      if (state == S_IDLE) begin
        pending <= 1'b0;
      end else if (window_ready) begin
        pending <= 1'b1;
      end

      if (drop && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_next   = state;
    mm_start     = 1'b0;
    feat_rd_en   = 1'b0;
    feat_rd_addr = '0;
    case (state)
      S_IDLE:  if (window_ready || pending) state_next = S_START;
      S_START: begin
        mm_start   = 1'b1;
        state_next = S_FEED;
      end
      S_FEED: begin
        feat_rd_en   = 1'b1;
        feat_rd_addr = counter;
        if (counter == LAST_BATCH) state_next = S_WAIT;
      end
      S_WAIT:  if (mm_result_valid) state_next = S_HOLD;
      S_HOLD:  if (gest_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // RAM data goes straight through; gating on the delayed strobe keeps the
  // engine input at zero outside the valid beats.
  assign mm_feature_valid = rd_en_q;
  assign mm_feature_in    = rd_en_q ? feat_rd_data : '0;
  assign gest_valid       = (state == S_HOLD);
  assign gest_class       = class_q;
  assign gest_low_conf    = low_conf_q;
  assign busy             = (state != S_IDLE);

endmodule

// File: tb/tb_classify_sequencer.sv
module tb_classify_sequencer;

  localparam int NUM_CLASSES = 4;
  localparam int NUM_CELLS   = 16;
  localparam int VALUE_BITS  = 6;
  localparam int ACC_BITS    = 24;
  localparam int PAR         = 4;
  localparam int MIN_MARGIN  = 64;
  localparam int DROP_BITS   = 2;
  localparam int BATCHES     = 4;
  localparam int BATCH_BITS  = 2;
  localparam int WORD        = PAR * VALUE_BITS;
  localparam int SW          = NUM_CLASSES * ACC_BITS;
`ifdef CLS_MARGIN_EN
  localparam bit MARGIN_ON = 1'b1;
`else
  localparam bit MARGIN_ON = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  window_ready = 1'b0;
  logic                  feat_rd_en;
  logic [BATCH_BITS-1:0] feat_rd_addr;
  logic [WORD-1:0]       feat_rd_data = '0;
  logic                  mm_start;
  logic [WORD-1:0]       mm_feature_in;
  logic                  mm_feature_valid;
  logic                  mm_result_valid;
  logic [1:0]            mm_best_class;
  logic [SW-1:0]         mm_scores_flat;
  logic                  gest_valid;
  logic                  gest_ready = 1'b0;
  logic [1:0]            gest_class;
  logic                  gest_low_conf;
  logic                  busy;
  logic [DROP_BITS-1:0]  drop_cnt;

  typedef struct { logic [1:0] cls; logic [SW-1:0] scores; } eng_t;
  typedef struct { logic [1:0] cls; logic low_conf; } exp_t;
  eng_t eng_q[$];
  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  bit inject_late = 1'b0;

  classify_sequencer #(
    .NUM_CLASSES(NUM_CLASSES), .NUM_CELLS(NUM_CELLS), .VALUE_BITS(VALUE_BITS),
    .ACC_BITS(ACC_BITS), .PARALLEL_INPUTS(PAR), .MIN_MARGIN(MIN_MARGIN),
    .DROP_BITS(DROP_BITS)
  ) dut (
    .clk(clk), .rst(rst), .window_ready(window_ready),
    .feat_rd_en(feat_rd_en), .feat_rd_addr(feat_rd_addr), .feat_rd_data(feat_rd_data),
    .mm_start(mm_start), .mm_feature_in(mm_feature_in), .mm_feature_valid(mm_feature_valid),
    .mm_result_valid(mm_result_valid), .mm_best_class(mm_best_class),
    .mm_scores_flat(mm_scores_flat), .gest_valid(gest_valid), .gest_ready(gest_ready),
    .gest_class(gest_class), .gest_low_conf(gest_low_conf), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [WORD-1:0] mem_word(input int a);
    return WORD'(a * 37 + 5);
  endfunction

  function automatic logic [SW-1:0] pack4(input int s0, input int s1, input int s2, input int s3);
    logic [SW-1:0] f;
    f[0*ACC_BITS +: ACC_BITS] = ACC_BITS'(s0);
    f[1*ACC_BITS +: ACC_BITS] = ACC_BITS'(s1);
    f[2*ACC_BITS +: ACC_BITS] = ACC_BITS'(s2);
    f[3*ACC_BITS +: ACC_BITS] = ACC_BITS'(s3);
    return f;
  endfunction

  // Feature RAM: one-cycle read latency.
  always @(posedge clk) if (feat_rd_en) feat_rd_data <= mem_word(int'(feat_rd_addr));

  // Engine model: counts beats after each start, answers 3 cycles after the last beat.
  initial begin
    int beats;
    int delay;
    eng_t r;
    beats = 0; delay = 0;
    mm_result_valid = 1'b0; mm_best_class = '0; mm_scores_flat = '0;
    forever begin
      @(negedge clk);
      mm_result_valid = 1'b0;
      if (inject_late) begin
        mm_result_valid = 1'b1; mm_best_class = 2'd2; inject_late = 1'b0;
      end
      if (mm_start) begin beats = 0; delay = 0; end
      if (mm_feature_valid) begin
        beats++;
        if (beats == BATCHES) begin beats = 0; delay = 3; end
      end else if (delay > 0) begin
        delay--;
        if (delay == 0 && eng_q.size() > 0) begin
          r = eng_q.pop_front();
          mm_result_valid = 1'b1; mm_best_class = r.cls; mm_scores_flat = r.scores;
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_job(input logic [1:0] cls, input logic [SW-1:0] sc, input logic lc);
    eng_t e;
    exp_t x;
    e.cls = cls; e.scores = sc;
    x.cls = cls; x.low_conf = lc;
    eng_q.push_back(e);
    exp_q.push_back(x);
  endtask

  // Waits at negedges for gest_valid; waited = cycles spent, got = seen.
  task automatic wait_result(input int max, output bit got, output int waited);
    got = 1'b0; waited = 0;
    while (waited < max) begin
      if (gest_valid) begin got = 1'b1; return; end
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic accept();
    gest_ready = 1'b1;
    @(negedge clk);
    gest_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycles(3);
    checks++; if ({busy, gest_valid, mm_start, feat_rd_en, mm_feature_valid} !== 5'b0) begin errors++; $display("[TB] FAIL reset_ctl got %b expected 00000", {busy, gest_valid, mm_start, feat_rd_en, mm_feature_valid}); end
    checks++; if (drop_cnt !== '0) begin errors++; $display("[TB] FAIL reset_drop got %0d expected 0", drop_cnt); end
    checks++; if ({gest_class, gest_low_conf, feat_rd_addr} !== 5'b0) begin errors++; $display("[TB] FAIL reset_data got %b expected 00000", {gest_class, gest_low_conf, feat_rd_addr}); end
    rst = 1'b0;
    cycles(1);
  endtask

  task automatic test_single_window();
    bit got;
    int waited;
    exp_t x;
    push_job(2'd2, pack4(10, 20, 300, 5), 1'b0);
    window_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      window_ready = 1'b0;
      checks++; if (mm_start !== (k == 1)) begin errors++; $display("[TB] FAIL start_c%0d got %b expected %b", k, mm_start, (k == 1)); end
      checks++; if (feat_rd_en !== (k >= 2 && k <= 5)) begin errors++; $display("[TB] FAIL rd_en_c%0d got %b expected %b", k, feat_rd_en, (k >= 2 && k <= 5)); end
      if (k >= 2 && k <= 5) begin
        checks++; if (feat_rd_addr !== BATCH_BITS'(k - 2)) begin errors++; $display("[TB] FAIL rd_addr_c%0d got %0d expected %0d", k, feat_rd_addr, k - 2); end
      end
      checks++; if (mm_feature_valid !== (k >= 3 && k <= 6)) begin errors++; $display("[TB] FAIL fvalid_c%0d got %b expected %b", k, mm_feature_valid, (k >= 3 && k <= 6)); end
      if (k >= 3 && k <= 6) begin
        checks++; if (mm_feature_in !== mem_word(k - 3)) begin errors++; $display("[TB] FAIL fdata_c%0d got %h expected %h", k, mm_feature_in, mem_word(k - 3)); end
      end
    end
    wait_result(40, got, waited);
    checks++; if (!got) begin errors++; $display("[TB] FAIL single_timeout got no gest_valid expected one"); end
    else begin
      checks++; if (waited + 8 !== 10) begin errors++; $display("[TB] FAIL single_latency got %0d expected 10", waited + 8); end
      x = exp_q.pop_front();
      checks++; if (gest_class !== x.cls) begin errors++; $display("[TB] FAIL single_class got %0d expected %0d", gest_class, x.cls); end
      checks++; if (gest_low_conf !== x.low_conf) begin errors++; $display("[TB] FAIL single_lowconf got %b expected %b", gest_low_conf, x.low_conf); end
      accept();
      checks++; if ({gest_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL single_release got %b expected 00", {gest_valid, busy}); end
    end
  endtask

  task automatic test_backpressure();
    bit got;
    int waited;
    int bad;
    exp_t x;
    push_job(2'd1, pack4(5, 400, 0, -20), 1'b0);
    window_ready = 1'b1; @(negedge clk); window_ready = 1'b0;
    wait_result(40, got, waited);
    checks++; if (!got) begin errors++; $display("[TB] FAIL bp_timeout got no gest_valid expected one"); end
    else begin
      x = exp_q.pop_front();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
        if (gest_valid !== 1'b1 || gest_class !== x.cls || mm_start !== 1'b0) bad++;
        @(negedge clk);
      end
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL bp_stable got %0d bad cycles expected 0", bad); end
      checks++; if (gest_class !== x.cls) begin errors++; $display("[TB] FAIL bp_class got %0d expected %0d", gest_class, x.cls); end
      accept();
      checks++; if ({gest_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL bp_release got %b expected 00", {gest_valid, busy}); end
    end
  endtask

  task automatic test_overrun();
    bit got;
    int waited;
    exp_t x;
    push_job(2'd3, pack4(0, 0, 10, 500), 1'b0);
    push_job(2'd0, pack4(900, 1, 2, 3), 1'b0);
    window_ready = 1'b1; @(negedge clk); window_ready = 1'b0;
    @(negedge clk);
    window_ready = 1'b1; cycles(3); window_ready = 1'b0;
    wait_result(40, got, waited);
    checks++; if (!got) begin errors++; $display("[TB] FAIL ovr_timeout1 got no gest_valid expected one"); end
    else begin
      x = exp_q.pop_front();
      checks++; if (gest_class !== x.cls) begin errors++; $display("[TB] FAIL ovr_class1 got %0d expected %0d", gest_class, x.cls); end
      checks++; if (drop_cnt !== 2'd2) begin errors++; $display("[TB] FAIL ovr_drops got %0d expected 2", drop_cnt); end
      accept();
      checks++; if ({mm_start, busy} !== 2'b00) begin errors++; $display("[TB] FAIL ovr_gap got %b expected 00", {mm_start, busy}); end
      @(negedge clk);
      checks++; if (mm_start !== 1'b1) begin errors++; $display("[TB] FAIL ovr_restart got %b expected 1", mm_start); end
      wait_result(40, got, waited);
      checks++; if (!got) begin errors++; $display("[TB] FAIL ovr_timeout2 got no gest_valid expected one"); end
      else begin
        x = exp_q.pop_front();
        checks++; if (gest_class !== x.cls) begin errors++; $display("[TB] FAIL ovr_class2 got %0d expected %0d", gest_class, x.cls); end
        accept();
        cycles(5);
        checks++; if ({busy, drop_cnt} !== {1'b0, 2'd2}) begin errors++; $display("[TB] FAIL ovr_idle got busy=%b drops=%0d expected busy=0 drops=2", busy, drop_cnt); end
      end
    end
  endtask

  task automatic test_saturation();
    bit got;
    int waited;
    exp_t x;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    checks++; if (drop_cnt !== '0) begin errors++; $display("[TB] FAIL sat_clear got %0d expected 0", drop_cnt); end
    push_job(2'd1, pack4(0, 300, 0, 0), 1'b0);
    push_job(2'd2, pack4(0, 0, 300, 0), 1'b0);
    window_ready = 1'b1; cycles(8); window_ready = 1'b0;
    checks++; if (drop_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_drops got %0d expected 3", drop_cnt); end
    for (int j = 0; j < 2; j++) begin
      wait_result(40, got, waited);
      checks++; if (!got) begin errors++; $display("[TB] FAIL sat_timeout%0d got no gest_valid expected one", j); end
      else begin
        x = exp_q.pop_front();
        checks++; if (gest_class !== x.cls) begin errors++; $display("[TB] FAIL sat_class%0d got %0d expected %0d", j, gest_class, x.cls); end
        accept();
      end
    end
    checks++; if (drop_cnt !== 2'd3) begin errors++; $display("[TB] FAIL sat_hold got %0d expected 3", drop_cnt); end
  endtask

  task automatic test_reset_mid_feed();
    int bad;
    window_ready = 1'b1; @(negedge clk); window_ready = 1'b0;
    cycles(3);
    checks++; if ({feat_rd_en, feat_rd_addr} !== 3'b110) begin errors++; $display("[TB] FAIL rmf_batch got %b expected 110", {feat_rd_en, feat_rd_addr}); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    checks++; if ({busy, mm_start, feat_rd_en, feat_rd_addr, mm_feature_valid, gest_valid, gest_class, gest_low_conf} !== 10'b0) begin errors++; $display("[TB] FAIL rmf_outputs got %b expected 0", {busy, mm_start, feat_rd_en, feat_rd_addr, mm_feature_valid, gest_valid, gest_class, gest_low_conf}); end
    checks++; if ({mm_feature_in, drop_cnt} !== '0) begin errors++; $display("[TB] FAIL rmf_data got %h expected 0", {mm_feature_in, drop_cnt}); end
    inject_late = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gest_valid !== 1'b0 || busy !== 1'b0 || mm_start !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL rmf_stale got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_margin();
    bit got;
    int waited;
    exp_t x;
    logic [SW-1:0] sc[3];
    logic lc[3];
    sc[0] = pack4(100, 90, -5, 0); lc[0] = MARGIN_ON;
    sc[1] = pack4(200, 90, 0, 0);  lc[1] = 1'b0;
    sc[2] = pack4(50, 50, -1, 7);  lc[2] = MARGIN_ON;
    for (int j = 0; j < 3; j++) begin
      push_job(2'd0, sc[j], lc[j]);
      window_ready = 1'b1; @(negedge clk); window_ready = 1'b0;
      wait_result(40, got, waited);
      checks++; if (!got) begin errors++; $display("[TB] FAIL margin_timeout%0d got no gest_valid expected one", j); end
      else begin
        x = exp_q.pop_front();
        checks++; if (gest_class !== x.cls) begin errors++; $display("[TB] FAIL margin_class%0d got %0d expected %0d", j, gest_class, x.cls); end
        checks++; if (gest_low_conf !== x.low_conf) begin errors++; $display("[TB] FAIL margin_lowconf%0d got %b expected %b", j, gest_low_conf, x.low_conf); end
        accept();
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_window();
    test_backpressure();
    test_overrun();
    test_saturation();
    test_reset_mid_feed();
    test_margin();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
